// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: line-state encoding and baud-timing derivation,
// common to the receive and transmit paths.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int sample_time(input int clock_freq, input int baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line plus byte-wide ready/valid output of the UART receiver.
interface uart_receiver_if;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    // master drives the line and consumes bytes; slave is the receiver
    modport master (
        output serial_in,
        output data_out_ready,
        input  data_out,
        input  data_out_valid,
        input  framing_error,
        input  overrun
    );

    modport slave (
        input  serial_in,
        input  data_out_ready,
        output data_out,
        output data_out_valid,
        output framing_error,
        output overrun
    );
endinterface

// File: rtl/uart_receiver_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle-high
// line shows no spurious edge after reset.
module uart_receiver_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: start-bit qualification, mid-bit sampling, stop-bit
// check, single-entry output buffer with sticky overrun.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 33_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.slave  rx_if
);
    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CTR_W            = $clog2(SYMBOL_EDGE_TIME) + 1;

    localparam logic [CTR_W-1:0] SAMPLE_LAST = CTR_W'(SAMPLE_TIME - 1);
    localparam logic [CTR_W-1:0] SYMBOL_LAST = CTR_W'(SYMBOL_EDGE_TIME - 1);

    logic              rx_s;
    logic              rx_prev_q;
    uart_state_e       state_q, state_d;
    logic [CTR_W-1:0]  clock_ctr_q, clock_ctr_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              framing_error_q, framing_error_d;
    logic              overrun_q, overrun_d;
    logic              byte_done;

    uart_receiver_sync #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_if.serial_in),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_prev_q       <= 1'b1;
            state_q         <= IDLE;
            clock_ctr_q     <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            valid_q         <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            rx_prev_q       <= rx_s;
            state_q         <= state_d;
            clock_ctr_q     <= clock_ctr_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        clock_ctr_d     = clock_ctr_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        data_d          = data_q;
        valid_d         = valid_q;
        framing_error_d = 1'b0;
        overrun_d       = overrun_q;
        byte_done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // edge-triggered only, so a held-low break never restarts a frame
                if (rx_prev_q && !rx_s) begin
                    state_d     = START;
                    clock_ctr_d = '0;
                end
            end
            START: begin
                if (clock_ctr_q == SAMPLE_LAST) begin
                    clock_ctr_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    clock_ctr_d = clock_ctr_q + 1'b1;
                end
            end
            DATA: begin
                if (clock_ctr_q == SYMBOL_LAST) begin
                    shift_d[bit_idx_q] = rx_s;
                    clock_ctr_d        = '0;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    clock_ctr_d = clock_ctr_q + 1'b1;
                end
            end
            STOP: begin
                if (clock_ctr_q == SYMBOL_LAST) begin
                    clock_ctr_d = '0;
                    state_d     = IDLE;
                    if (rx_s) begin
                        byte_done = 1'b1;
                    end else begin
                        framing_error_d = 1'b1;
                    end
                end else begin
                    clock_ctr_d = clock_ctr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // a consumer taking the old byte on the same edge frees the slot for the new one
        if (byte_done) begin
            if (!valid_q || rx_if.data_out_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_if.data_out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_if.data_out       = data_q;
    assign rx_if.data_out_valid = valid_q;
    assign rx_if.framing_error  = framing_error_q;
    assign rx_if.overrun        = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 1 MHz / 100 kbaud (10 clocks per bit).
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [7:0] hs_data[$];
    int         hs_cyc[$];
    int         valid_hi_cnt = 0;
    int         fe_cnt = 0;

    uart_receiver_if dif ();

    uart_receiver #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dif.data_out_valid && dif.data_out_ready) begin
            hs_data.push_back(dif.data_out);
            hs_cyc.push_back(cyc);
        end
        if (dif.data_out_valid) valid_hi_cnt <= valid_hi_cnt + 1;
        if (dif.framing_error)  fe_cnt <= fe_cnt + 1;
    end

    task automatic drive_bit(input logic b);
        dif.serial_in = b;
        repeat (10) @(negedge clk);
    endtask

    // called at a negedge; returns the cycle count at the moment the start bit is driven
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic test_reset;
        #3;
        tests_run++;
        if (dif.data_out !== 8'h00) begin
            tests_failed++; $display("FAIL reset_data_out: got %h want 00", dif.data_out);
        end
        tests_run++;
        if (dif.data_out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: got %b want 0", dif.data_out_valid);
        end
        tests_run++;
        if (dif.framing_error !== 1'b0) begin
            tests_failed++; $display("FAIL reset_framing_error: got %b want 0", dif.framing_error);
        end
        tests_run++;
        if (dif.overrun !== 1'b0) begin
            tests_failed++; $display("FAIL reset_overrun: got %b want 0", dif.overrun);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_byte;
        int base, vbase, fbase, st, lat;
        base = hs_data.size(); vbase = valid_hi_cnt; fbase = fe_cnt;
        send_frame(8'hA5, 1'b1, st);
        repeat (5) @(negedge clk);
        tests_run++;
        if (hs_data.size() !== base + 1) begin
            tests_failed++; $display("FAIL single_count: got %0d want %0d", hs_data.size() - base, 1);
        end else begin
            tests_run++;
            if (hs_data[base] !== 8'hA5) begin
                tests_failed++; $display("FAIL single_data: got %h want a5", hs_data[base]);
            end
            lat = hs_cyc[base] - (st + 1);
            tests_run++;
            if (lat < 97 || lat > 99) begin
                tests_failed++; $display("FAIL single_latency: got %0d want 98+-1", lat);
            end
        end
        tests_run++;
        if (valid_hi_cnt - vbase !== 1) begin
            tests_failed++; $display("FAIL single_valid_width: got %0d want 1", valid_hi_cnt - vbase);
        end
        tests_run++;
        if (fe_cnt !== fbase || dif.overrun !== 1'b0) begin
            tests_failed++; $display("FAIL single_errors: got fe=%0d ovr=%b want fe=0 ovr=0", fe_cnt - fbase, dif.overrun);
        end
    endtask

    task automatic test_back_to_back;
        int base, st0, st1, gap;
        base = hs_data.size();
        send_frame(8'h00, 1'b1, st0);
        send_frame(8'hFF, 1'b1, st1);
        repeat (5) @(negedge clk);
        tests_run++;
        if (hs_data.size() !== base + 2) begin
            tests_failed++; $display("FAIL b2b_count: got %0d want 2", hs_data.size() - base);
        end else begin
            tests_run++;
            if (hs_data[base] !== 8'h00 || hs_data[base+1] !== 8'hFF) begin
                tests_failed++; $display("FAIL b2b_data: got %h %h want 00 ff", hs_data[base], hs_data[base+1]);
            end
            gap = hs_cyc[base+1] - hs_cyc[base];
            tests_run++;
            if (gap < 99 || gap > 101) begin
                tests_failed++; $display("FAIL b2b_spacing: got %0d want 100+-1", gap);
            end
        end
    endtask

    task automatic test_glitch;
        int base, vbase, fbase;
        base = hs_data.size(); vbase = valid_hi_cnt; fbase = fe_cnt;
        dif.serial_in = 1'b0;
        repeat (3) @(negedge clk);
        dif.serial_in = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (hs_data.size() !== base || valid_hi_cnt !== vbase) begin
            tests_failed++; $display("FAIL glitch_valid: got %0d valid cycles want 0", valid_hi_cnt - vbase);
        end
        tests_run++;
        if (fe_cnt !== fbase) begin
            tests_failed++; $display("FAIL glitch_framing_error: got %0d want 0", fe_cnt - fbase);
        end
        tests_run++;
        if (dut.state_q !== IDLE) begin
            tests_failed++; $display("FAIL glitch_state: got %0d want %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_bad_stop;
        int vbase, fbase, st;
        vbase = valid_hi_cnt; fbase = fe_cnt;
        send_frame(8'h3C, 1'b0, st);
        tests_run++;
        if (fe_cnt - fbase !== 1) begin
            tests_failed++; $display("FAIL badstop_fe_pulse: got %0d cycles want 1", fe_cnt - fbase);
        end
        tests_run++;
        if (valid_hi_cnt !== vbase) begin
            tests_failed++; $display("FAIL badstop_valid: got %0d valid cycles want 0", valid_hi_cnt - vbase);
        end
        repeat (50) @(negedge clk);
        tests_run++;
        if (fe_cnt - fbase !== 1 || valid_hi_cnt !== vbase) begin
            tests_failed++; $display("FAIL break_quiet: got fe=%0d valid=%0d want fe=1 valid=0",
                                     fe_cnt - fbase, valid_hi_cnt - vbase);
        end
        tests_run++;
        if (dut.state_q !== IDLE) begin
            tests_failed++; $display("FAIL break_state: got %0d want %0d", dut.state_q, IDLE);
        end
        dif.serial_in = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_overrun;
        int base, st;
        base = hs_data.size();
        dif.data_out_ready = 1'b0;
        send_frame(8'h12, 1'b1, st);
        send_frame(8'h34, 1'b1, st);
        repeat (5) @(negedge clk);
        tests_run++;
        if (dif.data_out !== 8'h12 || dif.data_out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL overrun_hold: got data=%h valid=%b want data=12 valid=1",
                                     dif.data_out, dif.data_out_valid);
        end
        tests_run++;
        if (dif.overrun !== 1'b1) begin
            tests_failed++; $display("FAIL overrun_set: got %b want 1", dif.overrun);
        end
        dif.data_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (hs_data.size() !== base + 1 || dif.data_out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL overrun_consume: got %0d bytes valid=%b want 1 byte valid=0",
                                     hs_data.size() - base, dif.data_out_valid);
        end else begin
            tests_run++;
            if (hs_data[base] !== 8'h12) begin
                tests_failed++; $display("FAIL overrun_consume_data: got %h want 12", hs_data[base]);
            end
        end
        tests_run++;
        if (dif.overrun !== 1'b1) begin
            tests_failed++; $display("FAIL overrun_sticky: got %b want 1", dif.overrun);
        end
    endtask

    task automatic test_reset_mid_frame;
        int base, fbase, st;
        logic [7:0] pat;
        pat = 8'h5A;
        dif.data_out_ready = 1'b0;
        send_frame(8'h99, 1'b1, st);
        repeat (5) @(negedge clk);
        tests_run++;
        if (dif.data_out !== 8'h99 || dif.data_out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL prereset_hold: got data=%h valid=%b want data=99 valid=1",
                                     dif.data_out, dif.data_out_valid);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(pat[i]);
        dif.serial_in = pat[4];
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (dif.data_out !== 8'h00 || dif.data_out_valid !== 1'b0 ||
            dif.framing_error !== 1'b0 || dif.overrun !== 1'b0) begin
            tests_failed++; $display("FAIL midframe_async_reset: got data=%h valid=%b fe=%b ovr=%b want all 0",
                                     dif.data_out, dif.data_out_valid, dif.framing_error, dif.overrun);
        end
        dif.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        dif.data_out_ready = 1'b1;
        repeat (20) @(negedge clk);
        base = hs_data.size(); fbase = fe_cnt;
        send_frame(8'h81, 1'b1, st);
        repeat (5) @(negedge clk);
        tests_run++;
        if (hs_data.size() !== base + 1) begin
            tests_failed++; $display("FAIL postreset_count: got %0d want 1", hs_data.size() - base);
        end else begin
            tests_run++;
            if (hs_data[base] !== 8'h81) begin
                tests_failed++; $display("FAIL postreset_data: got %h want 81", hs_data[base]);
            end
        end
        tests_run++;
        if (fe_cnt !== fbase || dif.overrun !== 1'b0) begin
            tests_failed++; $display("FAIL postreset_errors: got fe=%0d ovr=%b want 0 0", fe_cnt - fbase, dif.overrun);
        end
    endtask

    initial begin
        reset = 1'b1;
        dif.serial_in = 1'b1;
        dif.data_out_ready = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_bad_stop();
        test_overrun();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
